md_sched: RTL
=============

// Module: md_sched
// PURPOSE
//  Multiply/divide scheduler for the 5-stage MIPS pipeline. Accepts MULT/MULTU/DIV/DIVU
//  from the E stage and holds HI/LO for MFHI/MFLO reads and MTHI/MTLO writes.
//  Models fixed multi-cycle latency with a busy counter.
//  Drives the stall that freezes F/D and bubbles the E register while the unit is busy.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for MULT/MULTU (1..15)
//  DIV_CYCLES   10  busy cycles for DIV/DIVU (1..15)
// PORTS
//  clk        in   1   system clock
//  reset      in   1   synchronous, active-high reset
//  start_E    in   1   E-stage instruction is an MD operation (any md_op_E below)
//  md_op_E    in   3   0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO (5/6 write rs_E)
//  rs_E       in   32  operand A (forwarded value)
//  rt_E       in   32  operand B (forwarded value)
//  rd_sel_E   in   2   0 none,1 MFHI,2 MFLO: selects md_out_E
//  md_use_D   in   1   D-stage instruction is MULT/DIV/MF*/MT*
//  busy       out  1   operation in flight
//  stall      out  1   freeze PC/F_REG/D_REG; insert bubble into E_REG
//  hi         out  32  architectural HI
//  lo         out  32  architectural LO
//  md_out_E   out  32  rd_sel_E==1 ? hi : rd_sel_E==2 ? lo : 0 (combinational)
// BEHAVIOUR
//  - Reset: busy=0, cnt=0, hi=lo=0, shadow hi/lo=0, stall=0. Reset mid-operation
//    discards the pending result; HI/LO read 0 in the next cycle.
//  - States: IDLE (busy=0), RUN (busy=1). cnt is 4 bits.
//  - IDLE & start_E & op in {1..4} at edge T: compute result into shadow regs.
//    Set cnt=N (MULT_CYCLES or DIV_CYCLES) and enter RUN.
//    busy=1 for exactly N cycles starting at T+1.
//  - RUN: cnt decrements each edge. At the edge where cnt==1: hi/lo<=shadow, busy falls.
//    New values are visible in the first cycle with busy=0.
//  - MULT: {hi,lo}=signed rs*rt (64b). MULTU: unsigned.
//  - DIV: lo=rs/rt, hi=rs%rt, signed, quotient truncated toward zero, remainder takes
//    the sign of the dividend. DIVU: unsigned.
//  - Divide by zero: shadow keeps the current hi/lo, so HI/LO are unchanged.
//    The full DIV_CYCLES busy period still runs.
//  - MTHI/MTLO in IDLE: hi (or lo) <= rs_E at the edge; no busy period.
//  - start_E while busy: ignored, no state change. Cannot occur in a legal pipeline
//    because stall holds the instruction in D. The bench asserts it never occurs.
//  - stall = md_use_D & (busy | (start_E & md_op_E in {1..4})).
//    Combinational, so it covers the start cycle too.
//  - md_out_E reads committed hi/lo only. It is never shadow data: an MF* is stalled
//    in D until busy=0.
//  - Width: products use 64-bit sign/zero-extended operands.
//    Division uses the 32-bit Verilog signed/unsigned operators.
// STRUCTURE
//  - Shared constants header: MD_NONE..MD_MTLO op codes and RD_HI/RD_LO selects.
//    The control decoder and the hazard unit share these.
//  - Single module, no sub-modules. Arithmetic inline.
//    Counter and state live in one always @(posedge clk).
//  - Top-level hazard unit ORs stall into its existing stall_D.
//    E_REG clear = stall (flush), as for load-use.
// TESTING
//  1 MULT rs=-3 rt=7 -> busy high 5 cycles; then hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
//  2 DIVU rs=100 rt=7 -> busy 10 cycles; then lo=14, hi=2.
//    DIV rs=-7 rt=2 -> lo=-3, hi=-1.
//  3 DIV rs=5 rt=0 with hi=lo=0x1234 -> busy 10 cycles; hi/lo stay 0x1234.
//  4 MULT then MFLO in D -> stall=1 from the start cycle through the last busy cycle.
//    Then md_out_E equals the new lo, with no stale read.
//  5 MTHI rs=0xDEADBEEF in IDLE -> hi=0xDEADBEEF next cycle, busy stays 0.
//    Independent instruction in D during a RUN -> stall=0.
//  6 reset asserted on the 3rd busy cycle of a DIV -> busy=0, hi=lo=0 next cycle.
//    No late writeback afterwards.

Source files
------------

// File: rtl/md_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | md_sched_pkg : MD operation codes and MF* read selects                |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
package md_sched_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    localparam logic [1:0] RD_NONE  = 2'd0;
    localparam logic [1:0] RD_HI    = 2'd1;
    localparam logic [1:0] RD_LO    = 2'd2;

    // Multi-cycle arithmetic ops; MT* are single-edge writes.
    function automatic logic md_is_arith(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage : md_sched_pkg
`default_nettype wire

// File: rtl/md_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | md_sched : multiply/divide scheduler with HI/LO and pipeline stall    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module md_sched
    import md_sched_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_E,
    input  logic [2:0]  md_op_E,
    input  logic [31:0] rs_E,
    input  logic [31:0] rt_E,
    input  logic [1:0]  rd_sel_E,
    input  logic        md_use_D,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out_E
);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_RUN   = 1'b1;
    localparam logic [3:0] c_MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] c_DIV_CNT  = 4'(DIV_CYCLES);

    logic [0:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_shadow_hi;
    logic [31:0] r_shadow_lo;

    logic               w_is_arith;
    logic               w_is_div;
    logic               w_issue;
    logic               w_mt_write;
    logic signed [63:0] w_a_sx;
    logic signed [63:0] w_b_sx;
    logic        [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic signed [31:0] w_rs_s;
    logic signed [31:0] w_rt_s;
    logic signed [31:0] w_quo_s;
    logic signed [31:0] w_rem_s;
    logic        [31:0] w_res_hi;
    logic        [31:0] w_res_lo;

    assign w_is_arith = md_is_arith(md_op_E);
    assign w_is_div   = (md_op_E == MD_DIV) || (md_op_E == MD_DIVU);
    assign w_issue    = (r_state == c_ST_IDLE) && start_E && w_is_arith;
    assign w_mt_write = (r_state == c_ST_IDLE) && start_E &&
                        ((md_op_E == MD_MTHI) || (md_op_E == MD_MTLO));

    assign w_a_sx   = {{32{rs_E[31]}}, rs_E};
    assign w_b_sx   = {{32{rt_E[31]}}, rt_E};
    assign w_prod_s = w_a_sx * w_b_sx;
    assign w_prod_u = {32'd0, rs_E} * {32'd0, rt_E};

    assign w_rs_s  = rs_E;
    assign w_rt_s  = rt_E;
    assign w_quo_s = w_rs_s / w_rt_s;
    assign w_rem_s = w_rs_s % w_rt_s;

    // A zero divisor keeps the committed HI/LO as the pending result.
    always_comb begin
        w_res_hi = r_hi;
        w_res_lo = r_lo;
        case (md_op_E)
            MD_MULT:  {w_res_hi, w_res_lo} = w_prod_s;
            MD_MULTU: {w_res_hi, w_res_lo} = w_prod_u;
            MD_DIV: begin
                if (rt_E != 32'd0) begin
                    w_res_hi = w_rem_s;
                    w_res_lo = w_quo_s;
                end
            end
            MD_DIVU: begin
                if (rt_E != 32'd0) begin
                    w_res_hi = rs_E % rt_E;
                    w_res_lo = rs_E / rt_E;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= 4'd0;
            r_hi        <= 32'd0;
            r_lo        <= 32'd0;
            r_shadow_hi <= 32'd0;
            r_shadow_lo <= 32'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_issue) begin
                        r_shadow_hi <= w_res_hi;
                        r_shadow_lo <= w_res_lo;
                        r_cnt       <= w_is_div ? c_DIV_CNT : c_MULT_CNT;
                        r_state     <= c_ST_RUN;
                    end else if (w_mt_write) begin
                        if (md_op_E == MD_MTHI) r_hi <= rs_E;
                        else                    r_lo <= rs_E;
                    end
                end
                c_ST_RUN: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_hi    <= r_shadow_hi;
                        r_lo    <= r_shadow_lo;
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign busy  = (r_state == c_ST_RUN);
    assign stall = md_use_D && (busy || (start_E && w_is_arith));
    assign hi    = r_hi;
    assign lo    = r_lo;

    always_comb begin
        md_out_E = 32'd0;
        case (rd_sel_E)
            RD_HI:   md_out_E = r_hi;
            RD_LO:   md_out_E = r_lo;
            default: md_out_E = 32'd0;
        endcase
    end

endmodule : md_sched
`default_nettype wire
